// File: rtl/lcd_pkg.sv
// Shared types, command bytes and default timing for the LCD frame writer.
// Imported by the nibble transmitter and the frame writer top.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWRUP_WAIT,
      INIT_NIB,
      INIT_CMD,
      IDLE,
      FRAME
   } state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SETUP,
      TX_HIGH,
      TX_WAIT
   } txph_e;

   typedef enum logic [1:0] {
      W_NIB,
      W_CHAR,
      W_INIT1,
      W_CLR
   } wsel_e;

   localparam logic [7:0] CMD_FUNC  = 8'h28;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_CLR   = 8'h01;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;

   localparam int unsigned DEF_T_PWRUP = 750000;
   localparam int unsigned DEF_T_SETUP = 2;
   localparam int unsigned DEF_T_EPW   = 12;
   localparam int unsigned DEF_T_NIB   = 50;
   localparam int unsigned DEF_T_CHAR  = 2000;
   localparam int unsigned DEF_T_INIT1 = 205000;
   localparam int unsigned DEF_T_CLR   = 82000;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      logic [7:0] c;
      unique case (i)
         2'd0:    c = CMD_FUNC;
         2'd1:    c = CMD_DISP;
         2'd2:    c = CMD_ENTRY;
         default: c = CMD_CLR;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// 4-bit HD44780 write bus: E strobe, RS select, RW (tied low), data nibble.
// master drives the pins, slave observes them.
interface lcd_frame_writer_if;
   logic       LCDE;
   logic       LCDRS;
   logic       LCDRW;
   logic [3:0] LCDDAT;

   modport master (output LCDE, LCDRS, LCDRW, LCDDAT);
   modport slave  (input  LCDE, LCDRS, LCDRW, LCDDAT);
endinterface

// File: rtl/lcd_nibble_tx.sv
// Sends one nibble: RS/DAT setup, E pulse, then a selectable post-fall wait.
// Ports: i_start/i_rs/i_nib/i_wsel in; o_done (last wait cycle), o_idle, pins out.
module lcd_nibble_tx
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP = DEF_T_SETUP,
   parameter int unsigned T_EPW   = DEF_T_EPW,
   parameter int unsigned T_NIB   = DEF_T_NIB,
   parameter int unsigned T_CHAR  = DEF_T_CHAR,
   parameter int unsigned T_INIT1 = DEF_T_INIT1,
   parameter int unsigned T_CLR   = DEF_T_CLR
) (
   input  logic       CCLK,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic       i_rs,
   input  logic [3:0] i_nib,
   input  wsel_e      i_wsel,
   output logic       o_done,
   output logic       o_idle,
   output logic       o_e,
   output logic       o_rs,
   output logic [3:0] o_dat
);

   txph_e       r_ph, w_ph_n;
   logic [19:0] r_cnt, w_cnt_n;
   logic [19:0] r_wait, w_wait_n;
   logic        r_e, w_e_n;
   logic        r_rs, w_rs_n;
   logic [3:0]  r_dat, w_dat_n;
   logic [19:0] w_wlen;
   logic        w_done;

   always_ff @(posedge CCLK or negedge rst_n) begin
      if (!rst_n) begin
         r_ph   <= TX_IDLE;
         r_cnt  <= '0;
         r_wait <= '0;
         r_e    <= 1'b0;
         r_rs   <= 1'b0;
         r_dat  <= 4'h0;
      end else begin
         r_ph   <= w_ph_n;
         r_cnt  <= w_cnt_n;
         r_wait <= w_wait_n;
         r_e    <= w_e_n;
         r_rs   <= w_rs_n;
         r_dat  <= w_dat_n;
      end
   end

   always_comb begin
      unique case (i_wsel)
         W_NIB:   w_wlen = 20'(T_NIB - 1);
         W_CHAR:  w_wlen = 20'(T_CHAR - 1);
         W_INIT1: w_wlen = 20'(T_INIT1 - 1);
         default: w_wlen = 20'(T_CLR - 1);
      endcase
   end

   // done is combinational so the next nibble can be latched on the
   // very edge that ends the wait, keeping gaps exact
   assign w_done = (r_ph == TX_WAIT) && (r_cnt == r_wait);

   always_comb begin
      w_ph_n   = r_ph;
      w_cnt_n  = r_cnt;
      w_wait_n = r_wait;
      w_e_n    = r_e;
      w_rs_n   = r_rs;
      w_dat_n  = r_dat;
      unique case (r_ph)
         TX_SETUP: begin
            if (r_cnt == 20'(T_SETUP - 1)) begin
               w_ph_n  = TX_HIGH;
               w_e_n   = 1'b1;
               w_cnt_n = '0;
            end else begin
               w_cnt_n = r_cnt + 20'd1;
            end
         end
         TX_HIGH: begin
            if (r_cnt == 20'(T_EPW - 1)) begin
               w_ph_n  = TX_WAIT;
               w_e_n   = 1'b0;
               w_cnt_n = '0;
            end else begin
               w_cnt_n = r_cnt + 20'd1;
            end
         end
         TX_WAIT: begin
            if (w_done) w_ph_n = TX_IDLE;
            else        w_cnt_n = r_cnt + 20'd1;
         end
         default: ;
      endcase
      if (i_start && ((r_ph == TX_IDLE) || w_done)) begin
         w_ph_n   = TX_SETUP;
         w_cnt_n  = '0;
         w_wait_n = w_wlen;
         w_rs_n   = i_rs;
         w_dat_n  = i_nib;
      end
   end

   assign o_done = w_done;
   assign o_idle = (r_ph == TX_IDLE);
   assign o_e    = r_e;
   assign o_rs   = r_rs;
   assign o_dat  = r_dat;

endmodule

// File: rtl/lcd_frame_writer.sv
// Drives a 16x2 HD44780 LCD: power-up init once, then 2-line frames on cls.
// Ports: CCLK, rst_n, cls, strdata in; busy, frame_done out; lcd bus master.
module lcd_frame_writer
   import lcd_pkg::*;
#(
   parameter int unsigned T_PWRUP = DEF_T_PWRUP,
   parameter int unsigned T_SETUP = DEF_T_SETUP,
   parameter int unsigned T_EPW   = DEF_T_EPW,
   parameter int unsigned T_NIB   = DEF_T_NIB,
   parameter int unsigned T_CHAR  = DEF_T_CHAR,
   parameter int unsigned T_INIT1 = DEF_T_INIT1,
   parameter int unsigned T_CLR   = DEF_T_CLR
) (
   input  logic                 CCLK,
   input  logic                 rst_n,
   input  logic                 cls,
   input  logic [255:0]         strdata,
   output logic                 busy,
   output logic                 frame_done,
   lcd_frame_writer_if.master   lcd
);

   state_e       r_st, w_st_n;
   logic [19:0]  r_cnt, w_cnt_n;
   logic [5:0]   r_byte, w_byte_n;
   logic         r_lo, w_lo_n;
   logic         r_pend, w_pend_n;
   logic         r_fdone, w_fdone_n;
   logic [255:0] r_shadow;
   logic         w_cap, w_start, w_rs, w_rdy, w_done, w_idle;
   logic [3:0]   w_nib;
   wsel_e        w_wsel;
   logic [7:0]   w_icmd, w_fbyte;
   logic [5:0]   w_idx;
   logic [4:0]   w_ci;

   lcd_nibble_tx #(
      .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_NIB(T_NIB),
      .T_CHAR(T_CHAR), .T_INIT1(T_INIT1), .T_CLR(T_CLR)
   ) u_tx (
      .CCLK(CCLK), .rst_n(rst_n),
      .i_start(w_start), .i_rs(w_rs), .i_nib(w_nib), .i_wsel(w_wsel),
      .o_done(w_done), .o_idle(w_idle),
      .o_e(lcd.LCDE), .o_rs(lcd.LCDRS), .o_dat(lcd.LCDDAT)
   );

   assign lcd.LCDRW  = 1'b0;
   assign w_rdy      = w_idle | w_done;
   assign busy       = (r_st != IDLE) || r_pend;
   assign frame_done = r_fdone;
   assign w_icmd     = init_cmd(r_byte[1:0]);

   // byte 0 and 17 are the line address commands; the rest index the
   // shadow string MSB-first, skipping the line-2 command slot
   always_comb begin
      w_idx = (r_byte < 6'd17) ? r_byte - 6'd1 : r_byte - 6'd2;
      w_ci  = 5'd31 - w_idx[4:0];
      unique case (1'b1)
         (r_byte == 6'd0):  w_fbyte = CMD_LINE1;
         (r_byte == 6'd17): w_fbyte = CMD_LINE2;
         default:           w_fbyte = r_shadow[{w_ci, 3'b000} +: 8];
      endcase
   end

   always_ff @(posedge CCLK or negedge rst_n) begin
      if (!rst_n) begin
         r_st     <= PWRUP_WAIT;
         r_cnt    <= '0;
         r_byte   <= '0;
         r_lo     <= 1'b0;
         r_pend   <= 1'b0;
         r_fdone  <= 1'b0;
         r_shadow <= '0;
      end else begin
         r_st    <= w_st_n;
         r_cnt   <= w_cnt_n;
         r_byte  <= w_byte_n;
         r_lo    <= w_lo_n;
         r_pend  <= w_pend_n;
         r_fdone <= w_fdone_n;
         if (w_cap) r_shadow <= strdata;
      end
   end

   // r_byte/r_lo point at the next nibble to send; byte 4 (init) and
   // byte 34 (frame) mean everything is issued and the last wait runs
   always_comb begin
      w_st_n    = r_st;
      w_cnt_n   = r_cnt;
      w_byte_n  = r_byte;
      w_lo_n    = r_lo;
      w_pend_n  = r_pend | cls;
      w_fdone_n = 1'b0;
      w_cap     = 1'b0;
      w_start   = 1'b0;
      w_rs      = 1'b0;
      w_nib     = 4'h0;
      w_wsel    = W_NIB;
      unique case (r_st)
         PWRUP_WAIT: begin
            w_cnt_n = r_cnt + 20'd1;
            if (r_cnt == 20'(T_PWRUP - 1)) begin
               w_start  = 1'b1;
               w_nib    = 4'h3;
               w_wsel   = W_INIT1;
               w_st_n   = INIT_NIB;
               w_byte_n = 6'd1;
            end
         end
         INIT_NIB: begin
            w_start = w_rdy;
            w_wsel  = W_CHAR;
            w_nib   = (r_byte == 6'd3) ? 4'h2 : 4'h3;
            if (w_rdy) begin
               if (r_byte == 6'd3) begin
                  w_st_n   = INIT_CMD;
                  w_byte_n = 6'd0;
                  w_lo_n   = 1'b0;
               end else begin
                  w_byte_n = r_byte + 6'd1;
               end
            end
         end
         INIT_CMD: begin
            if (r_byte == 6'd4) begin
               if (w_done) begin
                  w_st_n   = IDLE;
                  w_pend_n = 1'b1;
               end
            end else begin
               w_start = w_rdy;
               w_nib   = r_lo ? w_icmd[3:0] : w_icmd[7:4];
               w_wsel  = !r_lo ? W_NIB :
                         (r_byte == 6'd3) ? W_CLR : W_CHAR;
            end
         end
         IDLE: begin
            if (r_pend) begin
               w_cap    = 1'b1;
               w_st_n   = FRAME;
               w_byte_n = 6'd0;
               w_lo_n   = 1'b0;
               w_pend_n = cls;
            end
         end
         FRAME: begin
            if (r_byte == 6'd34) begin
               if (w_done) begin
                  w_st_n    = IDLE;
                  w_fdone_n = 1'b1;
               end
            end else begin
               w_start = w_rdy;
               w_rs    = (r_byte != 6'd0) && (r_byte != 6'd17);
               w_nib   = r_lo ? w_fbyte[3:0] : w_fbyte[7:4];
               w_wsel  = r_lo ? W_CHAR : W_NIB;
            end
         end
         default: w_st_n = PWRUP_WAIT;
      endcase
      if (w_start && (r_st == INIT_CMD || r_st == FRAME)) begin
         w_byte_n = r_lo ? r_byte + 6'd1 : r_byte;
         w_lo_n   = ~r_lo;
      end
   end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Self-checking bench for lcd_frame_writer with short timing parameters.
// A pin monitor captures every nibble and checks E/RS/DAT timing.
module tb_lcd_frame_writer;

   typedef struct packed {
      logic       rs;
      logic [3:0] nib;
   } nib_t;

   logic         CCLK = 1'b0;
   logic         rst_n = 1'b0;
   logic         cls = 1'b0;
   logic [255:0] strdata;
   logic         busy, frame_done;
   logic [255:0] s1, s2, s3;

   lcd_frame_writer_if lcd();

   lcd_frame_writer #(
      .T_PWRUP(20), .T_SETUP(1), .T_EPW(2), .T_NIB(3),
      .T_CHAR(5), .T_INIT1(8), .T_CLR(10)
   ) dut (
      .CCLK(CCLK), .rst_n(rst_n), .cls(cls), .strdata(strdata),
      .busy(busy), .frame_done(frame_done), .lcd(lcd)
   );

   always #5 CCLK = ~CCLK;

   nib_t cap[$];
   nib_t exp_q[$];
   nib_t init_tab[12];
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_fd = 0;
   int   edge_n = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic chk_ge(input string name, input int act, input int min);
      n_tests++;
      if (act < min) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected >= %0d", name, act, min);
      end
   endtask

   // pin monitor
   logic       m_pe, m_prs, m_hrs, m_pfd;
   logic [3:0] m_pdat, m_hdat;
   int         m_w, m_hold, m_fall, m_nr;

   always begin
      @(posedge CCLK);
      #1;
      edge_n++;
      if (!rst_n) begin
         m_pe = 0; m_prs = 0; m_pdat = 0; m_pfd = 0;
         m_w = 0; m_hold = 0; m_nr = 0;
      end else begin
         if (lcd.LCDE && !m_pe) begin
            chk("setup", {lcd.LCDRS, lcd.LCDDAT}, {m_prs, m_pdat});
            if (m_nr > 0) chk_ge("gap", edge_n - m_fall, 4);
            if (m_nr == 12) chk_ge("clr_gap", edge_n - m_fall, 11);
            cap.push_back(nib_t'({lcd.LCDRS, lcd.LCDDAT}));
            m_nr++;
            m_w = 1;
            m_hrs = lcd.LCDRS;
            m_hdat = lcd.LCDDAT;
         end else if (lcd.LCDE) begin
            m_w++;
            chk("e_high_hold", {lcd.LCDRS, lcd.LCDDAT}, {m_hrs, m_hdat});
         end else if (m_pe) begin
            chk("e_width", m_w, 2);
            chk("fall_hold", {lcd.LCDRS, lcd.LCDDAT}, {m_hrs, m_hdat});
            m_fall = edge_n;
            m_hold = 2;
         end else if (m_hold > 0) begin
            chk("post_hold", {lcd.LCDRS, lcd.LCDDAT}, {m_hrs, m_hdat});
            m_hold--;
         end
         if (frame_done) begin
            n_fd++;
            chk("fd_single", m_pfd, 0);
         end
         m_pe = lcd.LCDE;
         m_prs = lcd.LCDRS;
         m_pdat = lcd.LCDDAT;
         m_pfd = frame_done;
      end
   end

   function automatic void add_frame(input logic [255:0] s);
      logic [7:0] c;
      exp_q.push_back(nib_t'(5'h08));
      exp_q.push_back(nib_t'(5'h00));
      for (int k = 0; k < 32; k++) begin
         if (k == 16) begin
            exp_q.push_back(nib_t'(5'h0C));
            exp_q.push_back(nib_t'(5'h00));
         end
         c = s[255 - 8*k -: 8];
         exp_q.push_back(nib_t'({1'b1, c[7:4]}));
         exp_q.push_back(nib_t'({1'b1, c[3:0]}));
      end
   endfunction

   function automatic void add_init();
      for (int i = 0; i < 12; i++) exp_q.push_back(init_tab[i]);
   endfunction

   task automatic cmp_stream(input string tag);
      int n;
      chk({tag, "_count"}, cap.size(), exp_q.size());
      n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_nib%0d", tag, i), cap[i], exp_q[i]);
   endtask

   task automatic wait_fd(input int n, input int maxc);
      for (int i = 0; i < maxc && n_fd < n; i++) begin
         @(posedge CCLK);
         #2;
      end
      chk_ge("frame_done_wait", n_fd, n);
   endtask

   task automatic pulse_cls();
      @(negedge CCLK);
      cls = 1'b1;
      @(negedge CCLK);
      cls = 1'b0;
   endtask

   initial begin
      init_tab = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                   5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
      s1 = "01234567 00 0123f01d01e01m01w01 ";
      s2 = "ABCDEFGHIJKLMNOPqrstuvwxyz01234 ";
      s2[7:0] = 8'hFF;
      s3 = "line one data!! second line ok! ";
      strdata = s1;

      // reset state
      repeat (3) @(posedge CCLK);
      #2;
      chk("rst_e", lcd.LCDE, 0);
      chk("rst_rs", lcd.LCDRS, 0);
      chk("rst_rw", lcd.LCDRW, 0);
      chk("rst_dat", lcd.LCDDAT, 0);
      chk("rst_busy", busy, 1);
      chk("rst_fd", frame_done, 0);

      // first E rise exactly at cycle 21 after release
      @(negedge CCLK);
      rst_n = 1'b1;
      repeat (20) @(posedge CCLK);
      #2;
      chk("e_before21", lcd.LCDE, 0);
      @(posedge CCLK);
      #2;
      chk("e_at21", lcd.LCDE, 1);
      chk("dat_at21", lcd.LCDDAT, 4'h3);
      chk("rs_at21", lcd.LCDRS, 0);
      chk("busy_init", busy, 1);

      // automatic first frame
      add_init();
      add_frame(s1);
      wait_fd(1, 3000);
      chk("busy_after_f1", busy, 0);
      cmp_stream("f1");

      // coalesced cls and mid-frame strdata change
      cap.delete();
      exp_q.delete();
      n_fd = 0;
      strdata = s2;
      pulse_cls();
      repeat (60) @(negedge CCLK);
      strdata = s3;
      pulse_cls();
      repeat (20) @(negedge CCLK);
      pulse_cls();
      #1;
      chk("busy_pend", busy, 1);
      wait_fd(2, 4000);
      chk("busy_after_f3", busy, 0);
      repeat (600) @(posedge CCLK);
      #2;
      chk("no_extra_frame", n_fd, 2);
      chk("busy_quiet", busy, 0);
      add_frame(s2);
      add_frame(s3);
      cmp_stream("f23");
      if (cap.size() >= 68) begin
         chk("ff_hi", cap[66], 5'h1F);
         chk("ff_lo", cap[67], 5'h1F);
      end

      // asynchronous reset mid-frame
      cap.delete();
      exp_q.delete();
      n_fd = 0;
      pulse_cls();
      for (int i = 0; i < 500 && !(lcd.LCDE && lcd.LCDRS); i++) begin
         @(posedge CCLK);
         #2;
      end
      chk("midframe_data", {lcd.LCDE, lcd.LCDRS}, 2'b11);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_e", lcd.LCDE, 0);
      chk("arst_rs", lcd.LCDRS, 0);
      chk("arst_dat", lcd.LCDDAT, 0);
      chk("arst_busy", busy, 1);
      chk("arst_fd", frame_done, 0);
      repeat (3) @(posedge CCLK);
      cap.delete();
      n_fd = 0;
      @(negedge CCLK);
      rst_n = 1'b1;
      add_init();
      add_frame(s3);
      wait_fd(1, 3000);
      repeat (600) @(posedge CCLK);
      #2;
      chk("rst_one_frame", n_fd, 1);
      chk("rst_busy_idle", busy, 0);
      cmp_stream("f4");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Consumer end of the CPU debug-display path: takes the 32-character (256-bit) status string and a refresh strobe, and drives a 16x2 HD44780-compatible LCD over its 4-bit write-only bus. It performs the power-up init sequence once, then writes full two-line frames on request. It sits between the board top level, which builds the string from pipeline/register state, and the LCD pins.

## Interface
- T_PWRUP, 750000: cycles from reset release to first init nibble (15 ms at 50 MHz)
- T_SETUP, 2: cycles RS/DAT valid before E rises
- T_EPW, 12: E high width in cycles
- T_NIB, 50: wait after E falls, between the two nibbles of one byte
- T_CHAR, 2000: wait after E falls, after a data or non-clear command byte (40 us)
- T_INIT1, 205000: wait after first init nibble (4.1 ms)
- T_CLR, 82000: wait after clear command 0x01 (1.64 ms)
- CCLK  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cls  in  1  refresh request, one-cycle pulse
- strdata  in  256  characters; [255:248] = line 1 col 0, [127:120] = line 2 col 0
- LCDE  out  1  LCD enable strobe
- LCDRS  out  1  0 = command, 1 = data
- LCDRW  out  1  constant 0 (write only)
- LCDDAT  out  4  nibble bus
- busy  out  1  high while init or a frame is in progress or a request is pending
- frame_done  out  1  one-cycle pulse after the last nibble wait of a frame

## Operation
- States: PWRUP_WAIT -> INIT_NIB -> INIT_CMD -> IDLE <-> FRAME.
- PWRUP_WAIT: count T_PWRUP, then INIT_NIB.
- INIT_NIB: single nibbles, RS=0: 0x3 (wait T_INIT1), 0x3 (T_CHAR), 0x3 (T_CHAR), 0x2 (T_CHAR).
- INIT_CMD: bytes, RS=0, high nibble first: 0x28, 0x0C, 0x06, 0x01 (last waits T_CLR). Then pending request forced set (one automatic frame).
- IDLE: if pending, capture strdata into 256-bit shadow, clear pending, enter FRAME; else stay, busy=0.
- FRAME: 34 bytes: cmd 0x80; 16 data bytes from shadow[255:128], MSB byte first; cmd 0xC0; 16 data bytes from shadow[127:0]. Then frame_done pulse, IDLE.
- cls in any state sets pending; multiple cls before the frame starts coalesce into one frame. strdata is sampled only at FRAME entry; changes mid-frame do not affect the frame in progress.
- cls in the same cycle as the IDLE->FRAME capture: captured frame starts and pending remains set (one further frame follows).
- Data bytes are passed unmodified (no ASCII filtering).
- Byte counter is 6 bits, 0..33; index 0 and 17 are commands.

## Timing
- Reset values: LCDE 0, LCDRS 0, LCDRW 0, LCDDAT 0, busy 1, frame_done 0, pending 0, state PWRUP_WAIT. Assertion of rst_n mid-operation forces these immediately (asynchronous) and the full init sequence reruns after release.
- One nibble write: cycle 0 drive RS and DAT; E rises at cycle T_SETUP; E falls after T_EPW cycles high; RS/DAT held until next nibble starts; post-fall wait T_NIB (first nibble of byte) or the byte's wait (T_CHAR/T_INIT1/T_CLR) before next nibble's cycle 0.
- Next nibble never starts before the wait expires; no back-to-back E pulses.
- busy falls the cycle IDLE is entered with pending=0.

## Structure
- Shared package lcd_pkg: state encoding, init/command constants (0x28, 0x0C, 0x06, 0x01, 0x80, 0xC0), default timing values.
- Sub-module lcd_nibble_tx: start/rs/nibble/wait-select in, done pulse out; owns E timing, setup, and post-wait counter (20-bit). Parent FSM sequences bytes and nibbles.

## Test plan
Parameters for bench: T_PWRUP=20, T_SETUP=1, T_EPW=2, T_NIB=3, T_CHAR=5, T_INIT1=8, T_CLR=10.
- Reset release -> first LCDE rise at cycle 21 with RS=0, DAT=0x3; init nibble stream 3,3,3,2,2,8,0,C,0,6,0,1; busy stays 1.
- Automatic frame after init with strdata="01234567 00 0123f01d01e01m01w01 " -> nibbles 8,0 (RS=0), then 3,0,3,1,... (RS=1), C,0 (RS=0) after 16 chars; 68 E pulses total; frame_done pulses once; busy drops.
- Two cls pulses and a strdata change during a frame -> current frame shows old data; exactly one extra frame with new data.
- rst_n low mid-frame -> LCDE/LCDRS/LCDDAT 0 in the same cycle, busy 1; after release, full init restarts and no stale frame resumes.
- E timing checker: every LCDE high exactly 2 cycles; RS/DAT stable from 1 cycle before rise to at least 3 cycles after fall; 0x01 followed by 10-cycle gap.
- Data byte 0xFF in line 2 col 15 -> final nibbles F,F with RS=1, then frame_done.
